// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_rx_pkg;

  localparam int DATA_W = 8;

  // Encoding matches the transmitter so state dumps line up across the link.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Expected parity bit: typ=0 even, typ=1 odd.
  function automatic logic calc_par(input logic [DATA_W-1:0] data, input logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit oversampling counter and bit-value decision.
// UART_RX_MAJORITY_VOTE_EN selects 3-point majority voting instead of a single mid-bit sample.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic cnt_en,
  output logic rx_s,
  output logic sample_bit,
  output logic bit_end
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] MID  = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);

  logic          rx_m;
  logic [EW-1:0] edge_cnt;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !cnt_en || edge_cnt == LAST) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign bit_end = cnt_en && (edge_cnt == LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [EW-1:0] MID_LO = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] MID_HI = EW'(PRESCALE / 2 + 1);

  logic [2:0] votes;

  always_ff @(posedge clk) begin
    if (reset) begin
      votes <= 3'b111;
    end else if (cnt_en) begin
      if (edge_cnt == MID_LO) votes[0] <= rx_s;
      if (edge_cnt == MID)    votes[1] <= rx_s;
      if (edge_cnt == MID_HI) votes[2] <= rx_s;
    end
  end

  assign sample_bit = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
`else
  logic sample_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= 1'b1;
    end else if (cnt_en && edge_cnt == MID) begin
      sample_q <= rx_s;
    end
  end

  assign sample_bit = sample_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB-first, optional parity, stop; 1-cycle result pulses.
// Sampling mode (UART_RX_MAJORITY_VOTE_EN) is chosen inside uart_rx_sampler.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              Busy
);

  rx_state_e         state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_en_q;
  logic              par_typ_q;
  logic              par_bad;
  logic              rx_s;
  logic              sample_bit;
  logic              bit_end;
  logic              cnt_en;

  // The IDLE cycle that sees the start edge is not counted, so bit timing starts in START.
  assign cnt_en = (state != IDLE);
  assign Busy   = (state != IDLE);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (RX_IN),
    .cnt_en     (cnt_en),
    .rx_s       (rx_s),
    .sample_bit (sample_bit),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (bit_end) state <= sample_bit ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {sample_bit, shift_reg[DATA_W-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_bad <= (calc_par(shift_reg, par_typ_q) != sample_bit);
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            STP_ERR <= !sample_bit;
            PAR_ERR <= par_bad;
            if (sample_bit && !par_bad) begin
              P_DATA     <= shift_reg;
              DATA_VALID <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8: frame table plus glitch, back-to-back and reset sequences.
module tb_uart_rx;

  localparam int P = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  uart_rx #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tx_start_cyc;
  int dv_cnt, pe_cnt, se_cnt, dv_cyc;
  logic [7:0] dv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as a count above 1.
  always @(negedge clk) begin
    if (!reset) begin
      if (DATA_VALID) begin
        dv_cnt++;
        dv_cyc = cyc;
        dv_q.push_back(P_DATA);
      end
      if (PAR_ERR) pe_cnt++;
      if (STP_ERR) se_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; dv_cyc = -1;
    dv_q.delete();
  endtask

  // One bit period; glitch inverts the line for one cycle at the receiver's mid-bit sample point.
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < P; c++) begin
      RX_IN = (glitch && c == P / 2 + 1) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input logic flip, input int glitch_bit);
    tx_start_cyc = cyc + 1;
    drive_bit(1'b0, 1'b0);
    if (flip) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    for (int k = 0; k < 8; k++) drive_bit(d[k], glitch_bit == k);
    if (pe) drive_bit(pbit, 1'b0);
    drive_bit(sbit, 1'b0);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe, pt, pbit, sbit, flip;
    logic       dv, perr, serr;
    logic [7:0] pdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //            d      pe    pt    pbit  sbit  flip  dv    perr  serr  pdata
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[8] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};

    reset = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_p_data", P_DATA, 8'h00);
    check("rst_dv", DATA_VALID, 1'b0);
    check("rst_par_err", PAR_ERR, 1'b0);
    check("rst_stp_err", STP_ERR, 1'b0);
    check("rst_busy", Busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      clear_mon();
      PAR_EN  = vecs[i].pe;
      PAR_TYP = vecs[i].pt;
      send_frame(vecs[i].d, vecs[i].pe, vecs[i].pbit, vecs[i].sbit, vecs[i].flip, -1);
      repeat (2 * P) @(negedge clk);
      check($sformatf("v%0d_dv_cnt", i), dv_cnt, {31'd0, vecs[i].dv});
      check($sformatf("v%0d_par_err_cnt", i), pe_cnt, {31'd0, vecs[i].perr});
      check($sformatf("v%0d_stp_err_cnt", i), se_cnt, {31'd0, vecs[i].serr});
      check($sformatf("v%0d_p_data", i), P_DATA, vecs[i].pdata);
      check($sformatf("v%0d_busy_after", i), Busy, 1'b0);
      if (vecs[i].dv)
        check($sformatf("v%0d_latency", i), dv_cyc - tx_start_cyc,
              2 + (10 + (vecs[i].pe ? 1 : 0)) * P);
    end

    // Short low pulse in IDLE: START is entered, then the start sample reads 1.
    clear_mon();
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_start", Busy, 1'b1);
    repeat (2 * P) @(negedge clk);
    check("glitch_busy_idle", Busy, 1'b0);
    check("glitch_pulses", dv_cnt + pe_cnt + se_cnt, 0);
    check("glitch_p_data", P_DATA, 8'h5A);

    // Back-to-back frames with no idle gap.
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (2 * P) @(negedge clk);
    check("b2b_dv_cnt", dv_cnt, 2);
    check("b2b_first", (dv_q.size() > 0) ? dv_q[0] : 8'hxx, 8'h55);
    check("b2b_second", (dv_q.size() > 1) ? dv_q[1] : 8'hxx, 8'hAA);
    check("b2b_errs", pe_cnt + se_cnt, 0);

    // Reset during data bit 3 discards the frame and clears the outputs.
    clear_mon();
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      RX_IN = 1'b1;
      @(negedge clk);
    end
    check("mid_busy_before", Busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_p_data", P_DATA, 8'h00);
    check("mid_rst_dv", DATA_VALID, 1'b0);
    check("mid_rst_errs", {PAR_ERR, STP_ERR}, 2'b00);
    check("mid_rst_busy", Busy, 1'b0);
    repeat (2 * P) @(negedge clk);
    check("mid_rst_no_pulse", dv_cnt + pe_cnt + se_cnt, 0);
    clear_mon();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (2 * P) @(negedge clk);
    check("post_rst_dv_cnt", dv_cnt, 1);
    check("post_rst_p_data", P_DATA, 8'h0F);
    check("post_rst_latency", dv_cyc - tx_start_cyc, 2 + 10 * P);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle inverted glitch at the data-bit midpoint is outvoted.
    clear_mon();
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    repeat (2 * P) @(negedge clk);
    check("vote_dv_cnt", dv_cnt, 1);
    check("vote_p_data", P_DATA, 8'h96);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
